hs32_lsu: RTL and testbench

//  Parametrised load/store sequencer for the hs32 execute stage; generalises the single-word TM1/TM2 memory phase.

---
 rtl/hs32_lsu_if.sv | 63 ++++++
 rtl/hs32_lsu.sv | 229 ++++++++++++++++++++++
 tb/tb_hs32_lsu.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hs32_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : hs32_lsu_cmd_if / hs32_lsu_mem_if
// Description : Command-side (execute FSM) and memory-side (arbiter) bundles
//               for the hs32 load/store sequencer.
// Revision    : 1.0 - initial release
// ============================================================================

interface hs32_lsu_cmd_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 4
);
    logic          req;
    logic          rdy;
    logic          rw;
    logic [1:0]    size;
    logic          sext;
    logic [AW-1:0] base;
    logic [CW-1:0] count;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          wack;
    logic [CW-1:0] beat;
    logic          done;
    logic          err;

    modport master (
        output req, rw, size, sext, base, count, wdata,
        input  rdy, rdata, rvalid, wack, beat, done, err
    );

    modport slave (
        input  req, rw, size, sext, base, count, wdata,
        output rdy, rdata, rvalid, wack, beat, done, err
    );
endinterface

interface hs32_lsu_mem_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   addr;
    logic [DW-1:0]   dtwm;
    logic [DW-1:0]   dtrm;
    logic [DW/8-1:0] mask;
    logic            reqm;
    logic            rdym;
    logic            rw_mem;

    modport master (
        output addr, dtwm, mask, reqm, rw_mem,
        input  dtrm, rdym
    );

    modport slave (
        input  addr, dtwm, mask, reqm, rw_mem,
        output dtrm, rdym
    );
endinterface

`default_nettype wire

// File: rtl/hs32_lsu.sv
`default_nettype none
// ============================================================================
// Module      : hs32_lsu
// Description : Load/store sequencer with byte/half/word(/dword) sizes,
//               sign/zero extension, byte enables and multi-beat bursts.
//               Optional macro HS32_LSU_ALIGN_CHK_EN aborts misaligned commands.
// Revision    : 1.0 - initial release
// ============================================================================

module hs32_lsu #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           reset,
    hs32_lsu_cmd_if.slave  cmd,
    hs32_lsu_mem_if.master mem
);
    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          rw_q, rw_d;
    logic [1:0]    size_q, size_d;
    logic          sext_q, sext_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] beat_q, beat_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dtwm_q, dtwm_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [NB-1:0] mask_q, mask_d;
    logic          reqm_q, reqm_d;
    logic          rw_mem_q, rw_mem_d;
    logic          rvalid_q, rvalid_d;
    logic          wack_q, wack_d;
    logic          hs;

    function automatic logic [1:0] eff_size(input logic [1:0] sz);
        if (DW == 32 && sz == 2'd3) return 2'd2;
        return sz;
    endfunction

    function automatic logic [AW-1:0] align_down(input logic [AW-1:0] a, input logic [1:0] sz);
        return a & ~((AW'(1) << sz) - AW'(1));
    endfunction

`ifdef HS32_LSU_ALIGN_CHK_EN
    function automatic logic misaligned(input logic [AW-1:0] a, input logic [1:0] sz);
        return |(a & ((AW'(1) << sz) - AW'(1)));
    endfunction
`endif

    function automatic logic [NB-1:0] mask_of(input logic [AW-1:0] a, input logic [1:0] sz);
        logic [NB-1:0] m;
        int            lane;
        int            nbytes;
        lane   = int'(a[LB-1:0]);
        nbytes = 1 << sz;
        for (int j = 0; j < NB; j++) begin
            m[j] = (j >= lane) && (j < lane + nbytes);
        end
        return m;
    endfunction

    function automatic logic [DW-1:0] repl(input logic [DW-1:0] d, input logic [1:0] sz);
        logic [DW-1:0] r;
        case (sz)
            2'd0:    r = {NB{d[7:0]}};
            2'd1:    r = {(NB/2){d[15:0]}};
            2'd2:    r = {(NB/4){d[31:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [DW-1:0] extend(input logic [DW-1:0] v, input logic [1:0] sz,
                                             input logic sx);
        logic [DW-1:0] r;
        r = v;
        case (sz)
            2'd0:    for (int i = 8;  i < DW; i++) r[i] = sx & v[7];
            2'd1:    for (int i = 16; i < DW; i++) r[i] = sx & v[15];
            2'd2:    for (int i = 32; i < DW; i++) r[i] = sx & v[31];
            default: ;
        endcase
        return r;
    endfunction

    assign hs = (state_q == S_ACC) && reqm_q && mem.rdym;

    always_comb begin
        logic [1:0] sz_acc;
        state_d  = state_q;
        rw_d     = rw_q;
        size_d   = size_q;
        sext_d   = sext_q;
        count_d  = count_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        addr_d   = addr_q;
        dtwm_d   = dtwm_q;
        rdata_d  = rdata_q;
        mask_d   = mask_q;
        reqm_d   = reqm_q;
        rw_mem_d = rw_mem_q;
        rvalid_d = 1'b0;
        wack_d   = 1'b0;
        sz_acc   = eff_size(cmd.size);

        case (state_q)
            S_IDLE: begin
                if (cmd.req) begin
                    rw_d    = cmd.rw;
                    size_d  = sz_acc;
                    sext_d  = cmd.sext;
                    count_d = cmd.count;
                    cnt_d   = '0;
                    beat_d  = '0;
                    addr_d  = align_down(cmd.base, sz_acc);
                    mask_d  = mask_of(addr_d, sz_acc);
                    dtwm_d  = repl(cmd.wdata, sz_acc);
                    if (cmd.count == '0) begin
                        state_d = S_DONE;
                    end
`ifdef HS32_LSU_ALIGN_CHK_EN
                    else if (misaligned(cmd.base, sz_acc)) begin
                        state_d = S_ERR;
                    end
`endif
                    else begin
                        state_d  = S_ACC;
                        reqm_d   = 1'b1;
                        rw_mem_d = cmd.rw;
                    end
                end
            end
            S_ACC: begin
                if (hs) begin
                    if (rw_q) begin
                        wack_d = 1'b1;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = extend(mem.dtrm >> {addr_q[LB-1:0], 3'b000}, size_q, sext_q);
                    end
                    // beat reports the index of the beat whose pulse is being issued
                    beat_d = cnt_q;
                    cnt_d  = cnt_q + CW'(1);
                    addr_d = addr_q + (AW'(1) << size_q);
                    mask_d = mask_of(addr_d, size_q);
                    // wdata now carries the following beat's store data
                    dtwm_d = repl(cmd.wdata, size_q);
                    if (cnt_q == count_q - CW'(1)) begin
                        reqm_d   = 1'b0;
                        rw_mem_d = 1'b0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rw_q     <= 1'b0;
            size_q   <= 2'd0;
            sext_q   <= 1'b0;
            count_q  <= '0;
            cnt_q    <= '0;
            beat_q   <= '0;
            addr_q   <= '0;
            dtwm_q   <= '0;
            rdata_q  <= '0;
            mask_q   <= '0;
            reqm_q   <= 1'b0;
            rw_mem_q <= 1'b0;
            rvalid_q <= 1'b0;
            wack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            size_q   <= size_d;
            sext_q   <= sext_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            addr_q   <= addr_d;
            dtwm_q   <= dtwm_d;
            rdata_q  <= rdata_d;
            mask_q   <= mask_d;
            reqm_q   <= reqm_d;
            rw_mem_q <= rw_mem_d;
            rvalid_q <= rvalid_d;
            wack_q   <= wack_d;
        end
    end

    assign cmd.rdy    = (state_q == S_IDLE);
    assign cmd.done   = (state_q == S_DONE);
`ifdef HS32_LSU_ALIGN_CHK_EN
    assign cmd.err    = (state_q == S_ERR);
`else
    assign cmd.err    = 1'b0;
`endif
    assign cmd.rdata  = rdata_q;
    assign cmd.rvalid = rvalid_q;
    assign cmd.wack   = wack_q;
    assign cmd.beat   = beat_q;

    assign mem.addr   = addr_q;
    assign mem.dtwm   = dtwm_q;
    assign mem.mask   = mask_q;
    assign mem.reqm   = reqm_q;
    assign mem.rw_mem = rw_mem_q;

endmodule

`default_nettype wire

// File: tb/tb_hs32_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs32_lsu
// Description : Self-checking bench for hs32_lsu (DW=32) with a transaction-
//               level reference model and directed plus random commands.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_hs32_lsu;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hs32_lsu_cmd_if #(.AW(AW), .DW(DW), .CW(CW)) cmd_bus ();
    hs32_lsu_mem_if #(.AW(AW), .DW(DW))          mem_bus ();

    hs32_lsu #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .cmd   (cmd_bus),
        .mem   (mem_bus)
    );

    int n_chk;
    int n_fail;
    bit chk_en;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-addressed arithmetic on a 4-lane bus
    function automatic int eff(input int sz);
        return (sz == 3) ? 2 : sz;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] d, input logic [31:0] a,
                                           input int s, input bit sx);
        longint v;
        longint lim;
        v   = longint'(d) >> (8 * int'(a % 4));
        lim = longint'(1) << (8 << s);
        v   = v % lim;
        if (sx && s < 2 && v >= lim / 2) v = v - lim;
        return 32'(v);
    endfunction

    function automatic logic [31:0] m_dtwm(input logic [31:0] d, input int s);
        longint unit;
        longint r;
        int     nb;
        nb   = 1 << s;
        unit = longint'(d) % (longint'(1) << (8 * nb));
        r    = 0;
        for (int i = 0; i < 4 / nb; i++) r += unit << (8 * nb * i);
        return 32'(r);
    endfunction

    function automatic logic [3:0] m_mask(input logic [31:0] a, input int s);
        int lane;
        lane = int'(a % 4);
        return 4'(((1 << (1 << s)) - 1) << lane);
    endfunction

    task automatic run_cmd(input bit rw, input int sz, input bit sx, input logic [31:0] base,
                           input int cnt, input int lat, input logic [31:0] d0);
        int          s;
        int          bytes;
        int          l;
        logic [31:0] a0;
        logic [31:0] a;
        logic [31:0] data [16];
        s     = eff(sz);
        bytes = 1 << s;
        for (int i = 0; i < 16; i++) data[i] = $urandom;
        data[0] = d0;
        a0      = base & ~(32'(bytes) - 32'd1);

        chk("rdy_idle", cmd_bus.rdy, 1);
        cmd_bus.req   = 1'b1;
        cmd_bus.rw    = rw;
        cmd_bus.size  = 2'(sz);
        cmd_bus.sext  = sx;
        cmd_bus.base  = base;
        cmd_bus.count = 4'(cnt);
        cmd_bus.wdata = data[0];
        @(posedge clk); @(negedge clk);
        cmd_bus.req = 1'b0;

        if (cnt == 0) begin
            chk("done_cnt0", cmd_bus.done, 1);
            chk("reqm_cnt0", mem_bus.reqm, 0);
            @(negedge clk);
            chk("rdy_after_cnt0", cmd_bus.rdy, 1);
            chk("reqm_cnt0_b", mem_bus.reqm, 0);
            return;
        end
        if (chk_en && (base % bytes) != 0) begin
            chk("err_pulse", cmd_bus.err, 1);
            chk("reqm_err", mem_bus.reqm, 0);
            @(negedge clk);
            chk("err_clear", cmd_bus.err, 0);
            chk("reqm_err_b", mem_bus.reqm, 0);
            chk("rdy_after_err", cmd_bus.rdy, 1);
            return;
        end
        chk("err_none", cmd_bus.err, 0);

        for (int k = 0; k < cnt; k++) begin
            a = a0 + 32'(k * bytes);
            l = (lat < 0) ? int'($urandom_range(0, 2)) : lat;
            for (int w = 0; w <= l; w++) begin
                chk("reqm", mem_bus.reqm, 1);
                chk("addr", mem_bus.addr, a);
                chk("mask", mem_bus.mask, m_mask(a, s));
                chk("rw_mem", mem_bus.rw_mem, rw);
                if (rw) chk("dtwm", mem_bus.dtwm, m_dtwm(data[k], s));
                cmd_bus.wdata = data[k+1];
                if (w == l) begin
                    mem_bus.rdym = 1'b1;
                    mem_bus.dtrm = data[k];
                end else begin
                    mem_bus.rdym = 1'b0;
                    mem_bus.dtrm = $urandom;
                end
                @(posedge clk); @(negedge clk);
            end
            mem_bus.rdym = 1'b0;
            chk("beat", cmd_bus.beat, k);
            if (rw) begin
                chk("wack", cmd_bus.wack, 1);
                chk("rvalid_st", cmd_bus.rvalid, 0);
            end else begin
                chk("rvalid", cmd_bus.rvalid, 1);
                chk("rdata", cmd_bus.rdata, m_load(data[k], a, s, sx));
                chk("wack_ld", cmd_bus.wack, 0);
            end
            chk("done_flag", cmd_bus.done, (k == cnt - 1));
        end
        chk("reqm_end", mem_bus.reqm, 0);
        chk("rdy_busy", cmd_bus.rdy, 0);
        @(negedge clk);
        chk("rdy_end", cmd_bus.rdy, 1);
        chk("done_end", cmd_bus.done, 0);
    endtask

    initial begin
        int          rw;
        int          sz;
        int          sx;
        int          cnt;
        logic [31:0] base;
        n_chk  = 0;
        n_fail = 0;
`ifdef HS32_LSU_ALIGN_CHK_EN
        chk_en = 1'b1;
`else
        chk_en = 1'b0;
`endif
        reset         = 1'b1;
        cmd_bus.req   = 1'b0;
        cmd_bus.rw    = 1'b0;
        cmd_bus.size  = 2'd0;
        cmd_bus.sext  = 1'b0;
        cmd_bus.base  = '0;
        cmd_bus.count = '0;
        cmd_bus.wdata = '0;
        mem_bus.dtrm  = '0;
        mem_bus.rdym  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_rdy",    cmd_bus.rdy, 1);
        chk("rst_reqm",   mem_bus.reqm, 0);
        chk("rst_rw_mem", mem_bus.rw_mem, 0);
        chk("rst_rvalid", cmd_bus.rvalid, 0);
        chk("rst_wack",   cmd_bus.wack, 0);
        chk("rst_done",   cmd_bus.done, 0);
        chk("rst_err",    cmd_bus.err, 0);
        chk("rst_addr",   mem_bus.addr, 0);
        chk("rst_dtwm",   mem_bus.dtwm, 0);
        chk("rst_rdata",  cmd_bus.rdata, 0);
        chk("rst_mask",   mem_bus.mask, 0);
        chk("rst_beat",   cmd_bus.beat, 0);

        // rdym while no request is outstanding must do nothing
        mem_bus.rdym = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_rdym_rvalid", cmd_bus.rvalid, 0);
        chk("idle_rdym_wack",   cmd_bus.wack, 0);
        chk("idle_rdym_reqm",   mem_bus.reqm, 0);
        mem_bus.rdym = 1'b0;

        run_cmd(0, 2, 0, 32'h0000_0100, 1, 2, 32'hDEAD_BEEF);
        run_cmd(0, 0, 1, 32'h0000_0103, 1, 0, 32'h8000_0000);
        run_cmd(0, 0, 0, 32'h0000_0103, 1, 1, 32'h8000_0000);
        run_cmd(1, 1, 0, 32'h0000_0202, 1, 0, 32'h0000_1234);
        run_cmd(0, 2, 0, 32'hFFFF_FFF8, 4, 0, 32'h1111_2222);
        run_cmd(0, 2, 0, 32'h0000_0101, 1, 0, 32'h5555_AAAA);
        run_cmd(1, 0, 0, 32'h0000_0040, 0, 0, 32'h0);
        run_cmd(1, 2, 0, 32'h0000_0010, 3, -1, 32'hCAFE_F00D);
        run_cmd(0, 3, 1, 32'h0000_0020, 2, 0, 32'hF000_0001);

        // Reset during beat 2 of a 4-beat store
        @(negedge clk);
        cmd_bus.req   = 1'b1;
        cmd_bus.rw    = 1'b1;
        cmd_bus.size  = 2'd2;
        cmd_bus.base  = 32'h0000_0300;
        cmd_bus.count = 4'd4;
        cmd_bus.wdata = 32'hA5A5_0000;
        @(posedge clk); @(negedge clk);
        cmd_bus.req  = 1'b0;
        mem_bus.rdym = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("rst_mid_addr", mem_bus.addr, 32'h0000_0308);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset        = 1'b0;
        mem_bus.rdym = 1'b0;
        chk("rst_mid_reqm", mem_bus.reqm, 0);
        chk("rst_mid_rdy",  cmd_bus.rdy, 1);
        chk("rst_mid_done", cmd_bus.done, 0);
        chk("rst_mid_wack", cmd_bus.wack, 0);
        @(negedge clk);
        chk("rst_mid_done2", cmd_bus.done, 0);
        chk("rst_mid_reqm2", mem_bus.reqm, 0);
        run_cmd(0, 0, 0, 32'h0000_0000, 0, 0, 32'h0);

        for (int n = 0; n < 40; n++) begin
            rw   = int'($urandom_range(0, 1));
            sz   = int'($urandom_range(0, 3));
            sx   = int'($urandom_range(0, 1));
            cnt  = int'($urandom_range(0, 6));
            base = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
            if (cnt == 0) base = base & ~(32'(1 << eff(sz)) - 32'd1);
            run_cmd(rw[0], sz, sx[0], base, cnt, -1, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
